// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared Hack-style ALU.
// One operation is in flight at a time: IDLE accepts, EXEC drives the ALU, RESP holds the result.
module alu_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic [15:0] a_x,
    input  logic [15:0] a_y,
    input  logic [5:0]  a_op,
    output logic        a_rsp_valid,
    input  logic        a_rsp_ready,
    output logic [15:0] a_result,
    output logic        a_zr,
    output logic        a_ng,

    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic [15:0] b_x,
    input  logic [15:0] b_y,
    input  logic [5:0]  b_op,
    output logic        b_rsp_valid,
    input  logic        b_rsp_ready,
    output logic [15:0] b_result,
    output logic        b_zr,
    output logic        b_ng,

    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_zr,
    input  logic        alu_ng,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] op_x_q, op_x_d;
    logic [15:0] op_y_q, op_y_d;
    logic [5:0]  op_op_q, op_op_d;
    logic [15:0] res_q, res_d;
    logic        res_zr_q, res_zr_d;
    logic        res_ng_q, res_ng_d;
    logic        owner_q, owner_d;           // 0 = A, 1 = B
    logic        last_grant_q, last_grant_d; // 0 = A, 1 = B
    logic        grant_a_s, grant_b_s;
    logic        rsp_fire_s;

    // Arbitration: only in IDLE and never while reset is asserted.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if ((state_q == IDLE) && !rst) begin
            if (a_req_valid && b_req_valid) begin
                if ((RR == 1'b1) && (last_grant_q == 1'b0)) begin
                    grant_b_s = 1'b1;
                end else begin
                    grant_a_s = 1'b1;
                end
            end else if (a_req_valid) begin
                grant_a_s = 1'b1;
            end else if (b_req_valid) begin
                grant_b_s = 1'b1;
            end else begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign rsp_fire_s = owner_q ? b_rsp_ready : a_rsp_ready;

    // Next-state and datapath register update.
    always_comb begin
        state_d      = state_q;
        op_x_d       = op_x_q;
        op_y_d       = op_y_q;
        op_op_d      = op_op_q;
        res_d        = res_q;
        res_zr_d     = res_zr_q;
        res_ng_d     = res_ng_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant_a_s) begin
                    op_x_d       = a_x;
                    op_y_d       = a_y;
                    op_op_d      = a_op;
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = EXEC;
                end else if (grant_b_s) begin
                    op_x_d       = b_x;
                    op_y_d       = b_y;
                    op_op_d      = b_op;
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                res_d    = alu_result;
                res_zr_d = alu_zr;
                res_ng_d = alu_ng;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_fire_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset also abandons any response in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_x_q       <= 16'h0000;
            op_y_q       <= 16'h0000;
            op_op_q      <= 6'b000000;
            res_q        <= 16'h0000;
            res_zr_q     <= 1'b0;
            res_ng_q     <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_x_q       <= op_x_d;
            op_y_q       <= op_y_d;
            op_op_q      <= op_op_d;
            res_q        <= res_d;
            res_zr_q     <= res_zr_d;
            res_ng_q     <= res_ng_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign a_req_ready = grant_a_s;
    assign b_req_ready = grant_b_s;

    // Only the owner sees its response; the other side reads zeros.
    assign a_rsp_valid = (state_q == RESP) && !owner_q;
    assign b_rsp_valid = (state_q == RESP) && owner_q;
    assign a_result    = a_rsp_valid ? res_q : 16'h0000;
    assign a_zr        = a_rsp_valid & res_zr_q;
    assign a_ng        = a_rsp_valid & res_ng_q;
    assign b_result    = b_rsp_valid ? res_q : 16'h0000;
    assign b_zr        = b_rsp_valid & res_zr_q;
    assign b_ng        = b_rsp_valid & res_ng_q;

    assign alu_x  = op_x_q;
    assign alu_y  = op_y_q;
    assign alu_op = op_op_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational Hack-style ALU between two requesters, A and B.
- Each requester has a valid/ready request channel (x, y, op) and a valid/ready response channel (result, zr, ng).
- The block arbitrates between requesters, registers the operands that drive the ALU, captures the ALU outputs, and holds the response until the requester accepts it.
- It sits between the CPU-side clients and the ALU instance. The ALU is instantiated outside this block.

Parameters:
- RR, 1, arbitration mode. 1 = round-robin. 0 = fixed priority with A winning.
- Data width is fixed at 16 bits. Op width is fixed at 6 bits, encoded {no,f,ny,zy,nx,zx}, so op[0]=zx and op[5]=no.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- a_req_valid  input  1  requester A has an operation.
- a_req_ready  output  1  block accepts A's operation this cycle.
- a_x, a_y  input  16 each  A operands.
- a_op  input  6  A ALU control.
- a_rsp_valid  output  1  A response available.
- a_rsp_ready  input  1  A accepts its response.
- a_result  output  16  A result.
- a_zr, a_ng  output  1 each  A flags.
- b_*  same set as a_*, for requester B.
- alu_x, alu_y  output  16 each  operands to the shared ALU.
- alu_op  output  6  control to the shared ALU.
- alu_result  input  16  ALU output.
- alu_zr, alu_ng  input  1 each  ALU flags.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- FSM states:
  - IDLE: no operation in flight.
  - EXEC: operands applied to the ALU.
  - RESP: response held for the granted requester.
- Registers: op_x, op_y, op_op, res, res_zr, res_ng, owner (0=A, 1=B), last_grant.

Reset (rst=1 at a clock edge):
- state goes to IDLE.
- All *_req_ready and *_rsp_valid go to 0.
- Result and flag outputs, alu_x, alu_y and alu_op go to 0.
- last_grant goes to B, so A wins the first tie.
- Reset in any state, including mid-EXEC or RESP, aborts the operation and drops the response without a handshake.

Arbitration (combinational, in IDLE only):
- Only one valid: that requester wins.
- Both valid, RR=1: the requester not equal to last_grant wins.
- Both valid, RR=0: A wins.
- x_req_ready=1 only for the winner, only in IDLE, and only while rst=0. It is 0 in all other states.

Transitions:
- IDLE -> EXEC when the winner's handshake fires (valid & ready). On that edge: latch the operands and op, set owner and last_grant to the winner.
- EXEC -> RESP after exactly one cycle. alu_x, alu_y and alu_op are driven from the latched registers for the whole of EXEC. At the end of EXEC, capture alu_result, alu_zr and alu_ng into res, res_zr and res_ng.
- RESP: only the owner's rsp_valid=1. That owner's result and flag ports show the captured values, and they stay stable until accepted.
- RESP -> IDLE on owner rsp_valid & rsp_ready.
- No new request is accepted in the same cycle the response completes. The minimum issue interval is 3 cycles.

Latency and drive rules:
- Request accept edge at T. rsp_valid is high from T+2. The earliest accept is at edge T+2.
- A non-owner rsp_ready is ignored.
- The non-owner rsp_valid is 0 at all times.
- A requester holding valid while losing keeps its request pending. The block never drops it.
- Result and flags are passed through unmodified: no sign or width conversion, and 16-bit wrap is inherited from the ALU.
- In IDLE, the ALU outputs hold their last latched values.

Test Plan:
- A only: x=2, y=3, op=6'b010000 (x+y). Required: a_req_ready=1 in IDLE; a_rsp_valid rises 2 cycles after accept; a_result=5, zr=0, ng=0; b_rsp_valid stays 0.
- B only: x=2, y=3, op=6'b110010 (x-y). Required: b_result=16'hFFFF, ng=1, zr=0. Also hold b_rsp_ready=0 for 4 cycles; the response must stay stable, busy=1 and a_req_ready=0 throughout.
- Both valid continuously, RR=1, A op=6'b010101 (const 0), B op=6'b111111 (const 1). Required: grants alternate A, B, A, B; A returns result=0, zr=1; B returns result=1.
- Same stimulus with RR=0. Required: A is granted every time and B is never granted while A is valid.
- Assert rst during EXEC. Required: next cycle state is IDLE, busy=0, both rsp_valid=0; a subsequent request x=2, op=6'b001100 (x) completes normally with result=2.
- A at RESP with rsp_ready=1 while B is valid. Required: B's req_ready rises one cycle after the A response completes, not in the same cycle.
